// File: rtl/hdc_stream_monitor.sv
// Passive valid/ready tap: timestamps fin fires, measures latency on dout fires, counts stalls/idles and scores labels.
// All outputs registered (one cycle after the event edge); never drives the taps. Define HDC_MON_MINMAX_EN for lat_min/lat_max.
module hdc_stream_monitor #(
   parameter int NUM_LABELS   = 2,
   parameter int CNT_WIDTH    = 32,
   parameter int TS_WIDTH     = 24,
   parameter int MAX_INFLIGHT = 4,
   parameter int SKIP_FIRST   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  fin_valid,
   input  logic                  fin_ready,
   input  logic                  dout_valid,
   input  logic                  dout_ready,
   input  logic [NUM_LABELS-1:0] labels,
   input  logic [NUM_LABELS-1:0] exp_labels,
   output logic [CNT_WIDTH-1:0]  num_in,
   output logic [CNT_WIDTH-1:0]  num_out,
   output logic [CNT_WIDTH-1:0]  num_fail,
   output logic [CNT_WIDTH-1:0]  fin_stall_cnt,
   output logic [CNT_WIDTH-1:0]  fin_idle_cnt,
   output logic [CNT_WIDTH-1:0]  dout_stall_cnt,
   output logic [CNT_WIDTH-1:0]  dout_idle_cnt,
   output logic [CNT_WIDTH-1:0]  lat_total,
   output logic [TS_WIDTH-1:0]   last_latency,
   output logic [TS_WIDTH-1:0]   lat_min,
   output logic [TS_WIDTH-1:0]   lat_max,
   output logic [NUM_LABELS-1:0] mismatch_vec,
   output logic                  fail_pulse,
   output logic                  overflow,
   output logic                  underflow,
   output logic [1:0]            mon_state
);
   localparam int AW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int PCW = $clog2(NUM_LABELS + 1);
   localparam int MW  = (CNT_WIDTH > TS_WIDTH) ? CNT_WIDTH : TS_WIDTH;
   localparam int SW  = ((MW > PCW) ? MW : PCW) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] SKIP_IDX = CNT_WIDTH'(SKIP_FIRST);
   localparam logic [AW:0]          DEPTH    = (AW + 1)'(MAX_INFLIGHT);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_ERROR = 2'd2} state_t;

   // Adder is one bit wider than any operand so the carry flags saturation.
   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [SW-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + b;
      if (s > SW'(CNT_MAX)) sat_add = CNT_MAX;
      else                  sat_add = s[CNT_WIDTH-1:0];
   endfunction

   logic [TS_WIDTH-1:0]   mem_q [MAX_INFLIGHT];
   logic [TS_WIDTH-1:0]   mem_d [MAX_INFLIGHT];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]           cnt_q, cnt_d;
   logic [TS_WIDTH-1:0]   ts_q, ts_d, last_lat_q, last_lat_d;
   logic [CNT_WIDTH-1:0]  num_in_q, num_in_d, num_out_q, num_out_d, num_fail_q, num_fail_d;
   logic [CNT_WIDTH-1:0]  fin_stall_q, fin_stall_d, fin_idle_q, fin_idle_d;
   logic [CNT_WIDTH-1:0]  dout_stall_q, dout_stall_d, dout_idle_q, dout_idle_d;
   logic [CNT_WIDTH-1:0]  lat_total_q, lat_total_d;
   logic [NUM_LABELS-1:0] mism_q, mism_d;
   logic                  pulse_q, pulse_d, ovf_q, ovf_d, unf_q, unf_d;
   state_t                state_q, state_d;

   logic                  fin_fire, dout_fire, fifo_empty, fifo_full;
   logic                  push_ok, pop_ok, ovf_evt, unf_evt, score;
   logic [TS_WIDTH-1:0]   latency;
   logic [NUM_LABELS-1:0] xor_v;
   logic [PCW-1:0]        popcnt;

   assign fin_fire   = fin_valid & fin_ready;
   assign dout_fire  = dout_valid & dout_ready;
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == DEPTH);
   assign pop_ok     = dout_fire & ~fifo_empty;
   assign push_ok    = fin_fire & (~fifo_full | pop_ok);
   assign ovf_evt    = fin_fire & fifo_full & ~pop_ok;
   assign unf_evt    = dout_fire & fifo_empty;
   assign latency    = pop_ok ? (ts_q - mem_q[rd_ptr_q]) : '0;
   assign xor_v      = labels ^ exp_labels;
   assign score      = dout_fire & (num_out_q >= SKIP_IDX);

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < NUM_LABELS; i++) popcnt = popcnt + PCW'(xor_v[i]);
   end

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      ts_d         = ts_q + 1'b1;
      last_lat_d   = last_lat_q;
      num_in_d     = num_in_q;
      num_out_d    = num_out_q;
      num_fail_d   = num_fail_q;
      fin_stall_d  = fin_stall_q;
      fin_idle_d   = fin_idle_q;
      dout_stall_d = dout_stall_q;
      dout_idle_d  = dout_idle_q;
      lat_total_d  = lat_total_q;
      mism_d       = mism_q;
      pulse_d      = 1'b0;
      ovf_d        = ovf_q;
      unf_d        = unf_q;
      state_d      = state_q;
      if (clear) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         cnt_d        = '0;
         ts_d         = '0;
         last_lat_d   = '0;
         num_in_d     = '0;
         num_out_d    = '0;
         num_fail_d   = '0;
         fin_stall_d  = '0;
         fin_idle_d   = '0;
         dout_stall_d = '0;
         dout_idle_d  = '0;
         lat_total_d  = '0;
         mism_d       = '0;
         ovf_d        = 1'b0;
         unf_d        = 1'b0;
         state_d      = ST_IDLE;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = ts_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
         cnt_d = cnt_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
         if (fin_fire) num_in_d = sat_add(num_in_q, SW'(1));
         if (dout_fire) begin
            num_out_d   = sat_add(num_out_q, SW'(1));
            last_lat_d  = latency;
            lat_total_d = sat_add(lat_total_q, SW'(latency));
         end
         if (score) begin
            num_fail_d = sat_add(num_fail_q, SW'(popcnt));
            mism_d     = mism_q | xor_v;
            pulse_d    = |xor_v;
         end
         if (fin_valid & ~fin_ready)   fin_stall_d  = sat_add(fin_stall_q, SW'(1));
         if (~fin_valid & fin_ready)   fin_idle_d   = sat_add(fin_idle_q, SW'(1));
         if (dout_valid & ~dout_ready) dout_stall_d = sat_add(dout_stall_q, SW'(1));
         if (~dout_valid & dout_ready) dout_idle_d  = sat_add(dout_idle_q, SW'(1));
         if (ovf_evt) ovf_d = 1'b1;
         if (unf_evt) unf_d = 1'b1;
         // ERROR is absorbing until clear/rst; bookkeeping above keeps running in it.
         if (ovf_evt | unf_evt)
            state_d = ST_ERROR;
         else if ((state_q == ST_IDLE) && push_ok && fifo_empty)
            state_d = ST_BUSY;
         else if ((state_q == ST_BUSY) && pop_ok && !push_ok && (cnt_q == (AW + 1)'(1)))
            state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_INFLIGHT; i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         ts_q         <= '0;
         last_lat_q   <= '0;
         num_in_q     <= '0;
         num_out_q    <= '0;
         num_fail_q   <= '0;
         fin_stall_q  <= '0;
         fin_idle_q   <= '0;
         dout_stall_q <= '0;
         dout_idle_q  <= '0;
         lat_total_q  <= '0;
         mism_q       <= '0;
         pulse_q      <= 1'b0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         state_q      <= ST_IDLE;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         ts_q         <= ts_d;
         last_lat_q   <= last_lat_d;
         num_in_q     <= num_in_d;
         num_out_q    <= num_out_d;
         num_fail_q   <= num_fail_d;
         fin_stall_q  <= fin_stall_d;
         fin_idle_q   <= fin_idle_d;
         dout_stall_q <= dout_stall_d;
         dout_idle_q  <= dout_idle_d;
         lat_total_q  <= lat_total_d;
         mism_q       <= mism_d;
         pulse_q      <= pulse_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
         state_q      <= state_d;
      end
   end

`ifdef HDC_MON_MINMAX_EN
   logic [TS_WIDTH-1:0] lat_min_q, lat_min_d, lat_max_q, lat_max_d;

   // Underflow fires carry no real latency, so only true pops update the extremes.
   always_comb begin
      lat_min_d = lat_min_q;
      lat_max_d = lat_max_q;
      if (clear) begin
         lat_min_d = '1;
         lat_max_d = '0;
      end else if (pop_ok) begin
         if (latency < lat_min_q) lat_min_d = latency;
         if (latency > lat_max_q) lat_max_d = latency;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_min_q <= '1;
         lat_max_q <= '0;
      end else begin
         lat_min_q <= lat_min_d;
         lat_max_q <= lat_max_d;
      end
   end

   assign lat_min = lat_min_q;
   assign lat_max = lat_max_q;
`else
   assign lat_min = '0;
   assign lat_max = '0;
`endif

   assign num_in         = num_in_q;
   assign num_out        = num_out_q;
   assign num_fail       = num_fail_q;
   assign fin_stall_cnt  = fin_stall_q;
   assign fin_idle_cnt   = fin_idle_q;
   assign dout_stall_cnt = dout_stall_q;
   assign dout_idle_cnt  = dout_idle_q;
   assign lat_total      = lat_total_q;
   assign last_latency   = last_lat_q;
   assign mismatch_vec   = mism_q;
   assign fail_pulse     = pulse_q;
   assign overflow       = ovf_q;
   assign underflow      = unf_q;
   assign mon_state      = state_q;

endmodule

// File: tb/tb_hdc_stream_monitor.sv
// Directed bench for hdc_stream_monitor: timestamp scoreboard for latency/fail_pulse plus per-scenario counter checks.
module tb_hdc_stream_monitor;
   localparam int NL = 2, CW = 32, TW = 24, MI = 4, SK = 2;
`ifdef HDC_MON_MINMAX_EN
   localparam logic [63:0] LAT_MIN_RST = 64'hFF_FFFF;
`else
   localparam logic [63:0] LAT_MIN_RST = 64'h0;
`endif

   logic          clk = 1'b0, rst = 1'b1, clear = 1'b0;
   logic          fin_valid = 1'b0, fin_ready = 1'b0, dout_valid = 1'b0, dout_ready = 1'b0;
   logic [NL-1:0] labels = '0, exp_labels = '0;

   logic [CW-1:0] num_in, num_out, num_fail, fin_stall_cnt, fin_idle_cnt;
   logic [CW-1:0] dout_stall_cnt, dout_idle_cnt, lat_total;
   logic [TW-1:0] last_latency, lat_min, lat_max;
   logic [NL-1:0] mismatch_vec;
   logic          fail_pulse, overflow, underflow;
   logic [1:0]    mon_state;

   logic [3:0]    num_in_4, num_out_4, num_fail_4, fin_stall_4, fin_idle_4;
   logic [3:0]    dout_stall_4, dout_idle_4, lat_total_4;
   logic [TW-1:0] last_latency_4, lat_min_4, lat_max_4;
   logic [NL-1:0] mismatch_vec_4;
   logic          fail_pulse_4, overflow_4, underflow_4;
   logic [1:0]    mon_state_4;

   hdc_stream_monitor #(.NUM_LABELS(NL), .CNT_WIDTH(CW), .TS_WIDTH(TW), .MAX_INFLIGHT(MI), .SKIP_FIRST(SK)) u_dut (
      .clk(clk), .rst(rst), .clear(clear),
      .fin_valid(fin_valid), .fin_ready(fin_ready), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .labels(labels), .exp_labels(exp_labels),
      .num_in(num_in), .num_out(num_out), .num_fail(num_fail),
      .fin_stall_cnt(fin_stall_cnt), .fin_idle_cnt(fin_idle_cnt),
      .dout_stall_cnt(dout_stall_cnt), .dout_idle_cnt(dout_idle_cnt),
      .lat_total(lat_total), .last_latency(last_latency), .lat_min(lat_min), .lat_max(lat_max),
      .mismatch_vec(mismatch_vec), .fail_pulse(fail_pulse), .overflow(overflow),
      .underflow(underflow), .mon_state(mon_state));

   hdc_stream_monitor #(.NUM_LABELS(NL), .CNT_WIDTH(4), .TS_WIDTH(TW), .MAX_INFLIGHT(MI), .SKIP_FIRST(SK)) u_dut4 (
      .clk(clk), .rst(rst), .clear(clear),
      .fin_valid(fin_valid), .fin_ready(fin_ready), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .labels(labels), .exp_labels(exp_labels),
      .num_in(num_in_4), .num_out(num_out_4), .num_fail(num_fail_4),
      .fin_stall_cnt(fin_stall_4), .fin_idle_cnt(fin_idle_4),
      .dout_stall_cnt(dout_stall_4), .dout_idle_cnt(dout_idle_4),
      .lat_total(lat_total_4), .last_latency(last_latency_4), .lat_min(lat_min_4), .lat_max(lat_max_4),
      .mismatch_vec(mismatch_vec_4), .fail_pulse(fail_pulse_4), .overflow(overflow_4),
      .underflow(underflow_4), .mon_state(mon_state_4));

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0, n_fail = 0;
   int ts_m = 0, nout_m = 0, pulse_cnt = 0;
   int q_ts[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock: drive taps, push/pop the timestamp scoreboard, check what the DUT reports.
   task automatic cyc(input logic fv, input logic fr, input logic dv, input logic dr,
                      input logic [NL-1:0] lab, input logic [NL-1:0] ex);
      logic fin_f, dout_f, exp_pulse;
      int   exp_lat;
      fin_valid = fv; fin_ready = fr; dout_valid = dv; dout_ready = dr;
      labels = lab; exp_labels = ex;
      fin_f = fv & fr;
      dout_f = dv & dr;
      exp_lat = 0;
      if (dout_f && q_ts.size() > 0) exp_lat = ts_m - q_ts.pop_front();
      if (fin_f && q_ts.size() < MI) q_ts.push_back(ts_m);
      exp_pulse = dout_f && (nout_m >= SK) && (lab != ex);
      if (dout_f) nout_m++;
      @(posedge clk);
      ts_m++;
      #1;
      if (dout_f) chk("last_latency", 64'(last_latency), 64'(exp_lat));
      chk("fail_pulse", 64'(fail_pulse), 64'(exp_pulse));
      if (fail_pulse) pulse_cnt++;
   endtask

   task automatic cy4(input logic fv, input logic fr, input logic dv, input logic dr);
      cyc(fv, fr, dv, dr, 2'b00, 2'b00);
   endtask

   task automatic do_clear(input logic with_fire);
      clear = 1'b1;
      fin_valid = with_fire; fin_ready = with_fire; dout_valid = 1'b0; dout_ready = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      fin_valid = 1'b0; fin_ready = 1'b0;
      ts_m = 0; nout_m = 0; q_ts.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NL-1:0] la [4];
      logic [NL-1:0] le [4];
      la = '{2'b01, 2'b10, 2'b11, 2'b10};
      le = '{2'b01, 2'b01, 2'b00, 2'b10};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst num_in", 64'(num_in), 0);
      chk("rst lat_total", 64'(lat_total), 0);
      chk("rst mon_state", 64'(mon_state), 0);
      chk("rst overflow", 64'(overflow), 0);
      chk("rst lat_min", 64'(lat_min), LAT_MIN_RST);
      rst = 1'b0;
      ts_m = 0;

      // 1: fin fire at ts 10, dout fire at ts 25
      repeat (10) cy4(0, 0, 0, 0);
      cy4(1, 1, 0, 0);
      chk("t1 busy", 64'(mon_state), 1);
      repeat (14) cy4(0, 0, 0, 0);
      cy4(0, 0, 1, 1);
      chk("t1 num_in", 64'(num_in), 1);
      chk("t1 num_out", 64'(num_out), 1);
      chk("t1 last_latency", 64'(last_latency), 15);
      chk("t1 lat_total", 64'(lat_total), 15);
      chk("t1 idle", 64'(mon_state), 0);

      // 2: four pushes at ts 0-3, pops at ts 10-13
      do_clear(0);
      repeat (4) cy4(1, 1, 0, 0);
      chk("t2 busy", 64'(mon_state), 1);
      repeat (6) cy4(0, 0, 0, 0);
      repeat (4) cy4(0, 0, 1, 1);
      chk("t2 lat_total", 64'(lat_total), 40);
      chk("t2 overflow", 64'(overflow), 0);
      chk("t2 idle", 64'(mon_state), 0);
`ifdef HDC_MON_MINMAX_EN
      chk("t2 lat_min", 64'(lat_min), 10);
      chk("t2 lat_max", 64'(lat_max), 10);
`endif

      // 3a: five pushes, no pops
      do_clear(0);
      repeat (5) cy4(1, 1, 0, 0);
      chk("t3 overflow", 64'(overflow), 1);
      chk("t3 error", 64'(mon_state), 2);
      chk("t3 num_in", 64'(num_in), 5);
      // 3b: push+pop while full, drain, then pop empty
      do_clear(0);
      repeat (4) cy4(1, 1, 0, 0);
      cy4(1, 1, 1, 1);
      chk("t3 full push+pop overflow", 64'(overflow), 0);
      chk("t3 full push+pop state", 64'(mon_state), 1);
      chk("t3 full push+pop num_in", 64'(num_in), 5);
      repeat (4) cy4(0, 0, 1, 1);
      chk("t3 drained idle", 64'(mon_state), 0);
      cy4(0, 0, 1, 1);
      chk("t3 underflow", 64'(underflow), 1);
      chk("t3 underflow state", 64'(mon_state), 2);
      chk("t3 num_out", 64'(num_out), 6);
      chk("t3 lat_total", 64'(lat_total), 20);

      // 4: label scoring with SKIP_FIRST leading outputs ignored
      do_clear(0);
      pulse_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cy4(1, 1, 0, 0);
         cyc(0, 0, 1, 1, la[i], le[i]);
         if (i == 1) chk("t4 skipped num_fail", 64'(num_fail), 0);
      end
      cy4(0, 0, 0, 0);
      chk("t4 num_fail", 64'(num_fail), 2);
      chk("t4 mismatch_vec", 64'(mismatch_vec), 3);
      chk("t4 pulse count", 64'(pulse_cnt), 1);

      // 5: stall / idle counters and saturation on the 4-bit instance
      do_clear(0);
      repeat (7) cy4(1, 0, 0, 0);
      repeat (3) cy4(0, 0, 0, 1);
      chk("t5 fin_stall", 64'(fin_stall_cnt), 7);
      chk("t5 dout_idle", 64'(dout_idle_cnt), 3);
      chk("t5 fin_idle", 64'(fin_idle_cnt), 0);
      repeat (2) cy4(0, 0, 1, 0);
      cy4(0, 1, 0, 0);
      chk("t5 dout_stall", 64'(dout_stall_cnt), 2);
      chk("t5 fin_idle b", 64'(fin_idle_cnt), 1);
      repeat (13) cy4(1, 0, 0, 0);
      chk("t5 fin_stall 20", 64'(fin_stall_cnt), 20);
      chk("t5 fin_stall sat4", 64'(fin_stall_4), 15);

      // 6: clear with a same-cycle fire, then async reset mid-flight
      do_clear(0);
      cy4(1, 1, 0, 0);
      do_clear(1);
      chk("t6 clear num_in", 64'(num_in), 0);
      chk("t6 clear state", 64'(mon_state), 0);
      chk("t6 clear lat_min", 64'(lat_min), LAT_MIN_RST);
      cy4(0, 0, 1, 1);
      chk("t6 no push recorded", 64'(underflow), 1);
      do_clear(0);
      repeat (2) cy4(1, 1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6 async num_in", 64'(num_in), 0);
      chk("t6 async state", 64'(mon_state), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ts_m = 0; nout_m = 0; q_ts.delete();
      chk("t6 rst lat_min", 64'(lat_min), LAT_MIN_RST);
      chk("t6 rst num_out", 64'(num_out), 0);
      chk("t6 rst mismatch", 64'(mismatch_vec), 0);
      cy4(1, 1, 0, 0);
      cy4(0, 0, 1, 1);
      chk("t6 post rst underflow", 64'(underflow), 0);
      chk("t6 post rst num_in", 64'(num_in), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
